// File: rtl/fpu_row_fetcher_if.sv
// Memory-read and line-stream bus of the FPU row fetcher.
//   fetch_request/fetch_address     : line read request toward memory
//   fetch_data_valid/fetch_data     : returned 512-bit line
//   line_valid/line_ready           : handshake toward the filter datapath
//   line_data/line_row/line_last_in_row : registered line and its position
// master = fetcher side, slave = memory + datapath side.
interface fpu_row_fetcher_if;
   logic         fetch_request;
   logic [31:0]  fetch_address;
   logic         fetch_data_valid;
   logic [511:0] fetch_data;
   logic         line_valid;
   logic         line_ready;
   logic [511:0] line_data;
   logic [15:0]  line_row;
   logic         line_last_in_row;

   modport master (
      output fetch_request, fetch_address, line_valid, line_data, line_row, line_last_in_row,
      input  fetch_data_valid, fetch_data, line_ready
   );
   modport slave (
      input  fetch_request, fetch_address, line_valid, line_data, line_row, line_last_in_row,
      output fetch_data_valid, fetch_data, line_ready
   );
endinterface

// File: rtl/fpu_row_fetcher.sv
// Walks an 8-bit image row by row in 64-byte memory lines, one outstanding
// read at a time, and hands each line to the filter datapath.
//   clk, rst_n      : clock, synchronous active-low reset
//   fetch_start     : start pulse; image_width/height/start_address sampled then
//   busy            : high whenever not IDLE
//   fetch_done      : one-cycle pulse at the end of the image (or empty image)
//   bus (master)    : memory read request/response and line output stream
module fpu_row_fetcher #(
   parameter int LINE_BYTES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_start,
   input  logic [15:0] image_width,
   input  logic [15:0] image_height,
   input  logic [31:0] start_address,
   output logic        busy,
   output logic        fetch_done,
   fpu_row_fetcher_if.master bus
);
   localparam int SHIFT = $clog2(LINE_BYTES);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DONE} state_t;

   state_t       state, state_n;
   logic [15:0]  width_q, height_q;
   logic [15:0]  row, chunk;
   logic [31:0]  row_base;
   logic [16:0]  nchunks;
   logic         last_chunk, last_row, mem_take;
   logic [31:0]  line_addr;

   // 17-bit sum so width=0xFFFF does not overflow the round-up
   assign nchunks    = ({1'b0, width_q} + 17'(LINE_BYTES - 1)) >> SHIFT;
   assign last_chunk = ({1'b0, chunk} == nchunks - 17'd1);
   assign last_row   = (row == height_q - 16'd1);
   assign line_addr  = row_base + (32'(chunk) << SHIFT);

   // Data may come back in the very cycle the request first rises (REQ)
   assign mem_take = bus.fetch_data_valid && (state == REQ || state == WAIT);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (fetch_start)
                  state_n = (image_width == 16'd0 || image_height == 16'd0) ? DONE : REQ;
         REQ:  state_n = mem_take ? OUT : WAIT;
         WAIT: if (mem_take) state_n = OUT;
         OUT:  if (bus.line_ready) state_n = (last_chunk && last_row) ? DONE : REQ;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         width_q              <= '0;
         height_q             <= '0;
         row                  <= '0;
         chunk                <= '0;
         row_base             <= '0;
         bus.line_data        <= '0;
         bus.line_row         <= '0;
         bus.line_last_in_row <= 1'b0;
      end else begin
         if (state == IDLE && fetch_start) begin
            width_q  <= image_width;
            height_q <= image_height;
            row      <= '0;
            chunk    <= '0;
            row_base <= start_address;
         end
         if (mem_take) begin
            bus.line_data        <= bus.fetch_data;
            bus.line_row         <= row;
            bus.line_last_in_row <= last_chunk;
         end
         // Position advances on the handshake; after the final line the
         // counters are simply left alone until the next start.
         if (state == OUT && bus.line_ready) begin
            if (!last_chunk) begin
               chunk <= chunk + 16'd1;
            end else if (!last_row) begin
               chunk    <= '0;
               row      <= row + 16'd1;
               row_base <= row_base + {16'd0, width_q};
            end
         end
      end
   end

   assign bus.fetch_request = (state == REQ) || (state == WAIT);
   assign bus.fetch_address = bus.fetch_request ? line_addr : 32'd0;
   assign bus.line_valid    = (state == OUT);
   assign busy              = (state != IDLE);
   assign fetch_done        = (state == DONE);
endmodule

// File: tb/tb_fpu_row_fetcher.sv
// Directed bench for fpu_row_fetcher: reset values, full-line and partial-line
// rows, empty image, backpressure, address wrap and mid-operation reset.
module tb_fpu_row_fetcher;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_start;
   logic [15:0] image_width, image_height;
   logic [31:0] start_address;
   logic        busy, fetch_done;

   fpu_row_fetcher_if bus();

   fpu_row_fetcher #(.LINE_BYTES(64)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start),
      .image_width(image_width), .image_height(image_height),
      .start_address(start_address), .busy(busy), .fetch_done(fetch_done),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0]  q_addr[$];
   logic [15:0]  q_row[$];
   logic         q_last[$];
   logic [511:0] q_data[$];
   int           n_done;
   bit           tmo;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Plays memory (fast=1: answers in the request's first cycle, else one
   // cycle later) with line_ready tied high; records what comes out.
   // Returns one cycle after fetch_done, where busy must already be low.
   task automatic drive_image(input logic [15:0] w, input logic [15:0] h,
                              input logic [31:0] a, input bit fast);
      bit prev_req = 1'b0;
      q_addr.delete(); q_row.delete(); q_last.delete(); q_data.delete();
      n_done = 0; tmo = 1'b1;
      image_width = w; image_height = h; start_address = a;
      bus.line_ready = 1'b1;
      fetch_start = 1'b1;
      tick;
      fetch_start = 1'b0;
      for (int c = 0; c < 300; c++) begin
         bus.fetch_data_valid = 1'b0;
         if (fetch_done) n_done++;
         if (bus.line_valid && bus.line_ready) begin
            q_row.push_back(bus.line_row);
            q_last.push_back(bus.line_last_in_row);
            q_data.push_back(bus.line_data);
         end
         if (bus.fetch_request) begin
            if (!prev_req) q_addr.push_back(bus.fetch_address);
            if (prev_req || fast) begin
               bus.fetch_data_valid = 1'b1;
               bus.fetch_data = {16{bus.fetch_address}};
            end
         end
         prev_req = bus.fetch_request;
         if (fetch_done) begin
            tmo = 1'b0;
            tick;
            break;
         end
         tick;
      end
      bus.fetch_data_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick; tick;
      checks++; if (bus.fetch_request !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.fetch_request); end
      checks++; if (bus.fetch_address !== 32'd0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.fetch_address); end
      checks++; if (bus.line_valid !== 1'b0) begin errors++; $display("FAIL reset_line_valid got %b want 0", bus.line_valid); end
      checks++; if (bus.line_data !== 512'd0) begin errors++; $display("FAIL reset_line_data not zero"); end
      checks++; if (bus.line_row !== 16'd0 || bus.line_last_in_row !== 1'b0) begin errors++; $display("FAIL reset_row_last got %h/%b want 0/0", bus.line_row, bus.line_last_in_row); end
      checks++; if (busy !== 1'b0 || fetch_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b/%b want 0/0", busy, fetch_done); end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_full_rows;
      logic [31:0] exp_a[2] = '{32'h1000, 32'h1040};
      drive_image(16'd64, 16'd2, 32'h1000, 1'b0);
      checks++; if (tmo) begin errors++; $display("FAIL full_timeout got timeout want fetch_done"); end
      checks++; if (q_addr.size() != 2 || q_row.size() != 2) begin errors++; $display("FAIL full_count got %0d req %0d lines want 2/2", q_addr.size(), q_row.size()); end
      else begin
         for (int i = 0; i < 2; i++) begin
            checks++; if (q_addr[i] !== exp_a[i]) begin errors++; $display("FAIL full_addr%0d got %h want %h", i, q_addr[i], exp_a[i]); end
            checks++; if (q_row[i] !== 16'(i) || q_last[i] !== 1'b1) begin errors++; $display("FAIL full_line%0d got row %0d last %b want %0d/1", i, q_row[i], q_last[i], i); end
            checks++; if (q_data[i] !== {16{exp_a[i]}}) begin errors++; $display("FAIL full_data%0d got %h want pattern of %h", i, q_data[i][31:0], exp_a[i]); end
         end
      end
      checks++; if (n_done != 1) begin errors++; $display("FAIL full_done got %0d want 1", n_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b want 0", busy); end
   endtask

   task automatic test_partial_rows;
      logic [31:0] exp_a[4] = '{32'h2000, 32'h2040, 32'h2064, 32'h20A4};
      logic [15:0] exp_r[4] = '{16'd0, 16'd0, 16'd1, 16'd1};
      logic        exp_l[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      drive_image(16'd100, 16'd2, 32'h2000, 1'b0);
      checks++; if (tmo || q_addr.size() != 4 || q_row.size() != 4) begin errors++; $display("FAIL partial_count got %0d req %0d lines tmo %0b want 4/4", q_addr.size(), q_row.size(), tmo); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (q_addr[i] !== exp_a[i]) begin errors++; $display("FAIL partial_addr%0d got %h want %h", i, q_addr[i], exp_a[i]); end
            checks++; if (q_row[i] !== exp_r[i] || q_last[i] !== exp_l[i]) begin errors++; $display("FAIL partial_line%0d got row %0d last %b want %0d/%b", i, q_row[i], q_last[i], exp_r[i], exp_l[i]); end
         end
      end
      checks++; if (n_done != 1) begin errors++; $display("FAIL partial_done got %0d want 1", n_done); end
   endtask

   task automatic test_empty;
      image_width = 16'd0; image_height = 16'd5; start_address = 32'h5000;
      fetch_start = 1'b1;
      tick;
      fetch_start = 1'b0;
      checks++; if (fetch_done !== 1'b1 || bus.fetch_request !== 1'b0) begin errors++; $display("FAIL empty_done got done %b req %b want 1/0", fetch_done, bus.fetch_request); end
      tick;
      checks++; if (fetch_done !== 1'b0 || busy !== 1'b0 || bus.fetch_request !== 1'b0) begin errors++; $display("FAIL empty_after got done %b busy %b req %b want 0/0/0", fetch_done, busy, bus.fetch_request); end
   endtask

   task automatic test_backpressure;
      logic [511:0] d = {16{32'hA5C3_0F1E}};
      image_width = 16'd64; image_height = 16'd2; start_address = 32'h3000;
      bus.line_ready = 1'b0;
      fetch_start = 1'b1;
      tick;
      fetch_start = 1'b0;
      checks++; if (bus.fetch_request !== 1'b1 || bus.fetch_address !== 32'h3000) begin errors++; $display("FAIL bp_req got %b %h want 1 3000", bus.fetch_request, bus.fetch_address); end
      tick;
      bus.fetch_data_valid = 1'b1; bus.fetch_data = d;
      tick;
      bus.fetch_data_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.line_valid !== 1'b1 || bus.line_data !== d || bus.line_row !== 16'd0 ||
             bus.line_last_in_row !== 1'b1 || bus.fetch_request !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got valid %b row %0d last %b req %b data_ok %b want 1/0/1/0/1", i,
                     bus.line_valid, bus.line_row, bus.line_last_in_row, bus.fetch_request, bus.line_data === d);
         end
         // a start pulse while busy must be ignored
         fetch_start = (i == 2);
         image_width = 16'd0;
         tick;
      end
      fetch_start = 1'b0;
      bus.line_ready = 1'b1;
      tick;
      checks++; if (bus.fetch_request !== 1'b1 || bus.fetch_address !== 32'h3040 || bus.line_valid !== 1'b0) begin errors++; $display("FAIL bp_next_req got req %b addr %h valid %b want 1 3040 0", bus.fetch_request, bus.fetch_address, bus.line_valid); end
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_wrap_fast;
      drive_image(16'd64, 16'd2, 32'hFFFF_FFC0, 1'b1);
      checks++; if (tmo || q_addr.size() != 2) begin errors++; $display("FAIL wrap_count got %0d req tmo %0b want 2", q_addr.size(), tmo); end
      else begin
         checks++; if (q_addr[0] !== 32'hFFFF_FFC0 || q_addr[1] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got %h %h want ffffffc0 00000000", q_addr[0], q_addr[1]); end
      end
      checks++; if (q_data.size() != 2 || q_data[1] !== 512'd0) begin errors++; $display("FAIL wrap_data got %0d lines want 2 with zero last line", q_data.size()); end
   endtask

   task automatic test_reset_mid;
      image_width = 16'd64; image_height = 16'd2; start_address = 32'h4000;
      bus.line_ready = 1'b1;
      fetch_start = 1'b1;
      tick;
      fetch_start = 1'b0;
      tick;
      checks++; if (bus.fetch_request !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_wait got req %b busy %b want 1/1", bus.fetch_request, busy); end
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      checks++; if (bus.fetch_request !== 1'b0 || bus.fetch_address !== 32'd0 || bus.line_valid !== 1'b0 || busy !== 1'b0 || fetch_done !== 1'b0) begin errors++; $display("FAIL mid_reset got req %b addr %h valid %b busy %b done %b want all 0", bus.fetch_request, bus.fetch_address, bus.line_valid, busy, fetch_done); end
      bus.fetch_data_valid = 1'b1; bus.fetch_data = {512{1'b1}};
      tick;
      bus.fetch_data_valid = 1'b0;
      checks++; if (bus.line_valid !== 1'b0 || busy !== 1'b0 || bus.line_data !== 512'd0) begin errors++; $display("FAIL mid_late_data got valid %b busy %b data_zero %b want 0/0/1", bus.line_valid, busy, bus.line_data === 512'd0); end
      tick;
      checks++; if (fetch_done !== 1'b0 || bus.line_valid !== 1'b0) begin errors++; $display("FAIL mid_no_done got done %b valid %b want 0/0", fetch_done, bus.line_valid); end
   endtask

   initial begin
      rst_n = 1'b0; fetch_start = 1'b0;
      image_width = '0; image_height = '0; start_address = '0;
      bus.fetch_data_valid = 1'b0; bus.fetch_data = '0; bus.line_ready = 1'b0;
      test_reset;
      test_full_rows;
      test_partial_rows;
      test_empty;
      test_backpressure;
      test_wrap_fast;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
